// File: rtl/cvxif_offload_ctrl_pkg.sv
// rtl/cvxif_offload_ctrl_pkg.sv - shared CV-X-IF offload types and configuration
package cvxif_offload_ctrl_pkg;

    localparam int CFG_XLEN           = 32;
    localparam int CFG_NR_OUTSTANDING = 4;
    localparam int ID_WIDTH           = $clog2(CFG_NR_OUTSTANDING);

    typedef logic [ID_WIDTH-1:0] id_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef struct packed {
        logic       valid;
        logic       wb;
        logic       killed;
        logic [4:0] rd;
    } entry_t;

endpackage

// File: rtl/cvxif_id_table.sv
// rtl/cvxif_id_table.sv - in-flight offload ID table with lowest-free encoder
module cvxif_id_table
    import cvxif_offload_ctrl_pkg::*;
#(
    parameter int NrOutstanding = CFG_NR_OUTSTANDING,
    parameter int IdWidth       = $clog2(NrOutstanding)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_en,
    input  logic [IdWidth-1:0] alloc_id,
    input  entry_t             alloc_entry,
    input  logic               kill_all,
    input  logic               free_en,
    input  logic [IdWidth-1:0] free_id,
    input  logic [IdWidth-1:0] lookup_id,
    output entry_t             lookup_entry,
    output logic [IdWidth-1:0] free_idx,
    output logic               full,
    output logic               any_valid
);

    entry_t entries [NrOutstanding];

    // Free and allocate never target the same slot: a freed slot was valid, an allocated one was not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NrOutstanding; i++) begin
                entries[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NrOutstanding; i++) begin
                if (free_en && free_id == IdWidth'(i)) begin
                    entries[i] <= '0;
                end else if (alloc_en && alloc_id == IdWidth'(i)) begin
                    entries[i] <= alloc_entry;
                end else if (kill_all && entries[i].valid) begin
                    entries[i].killed <= 1'b1;
                end
            end
        end
    end

    assign lookup_entry = entries[lookup_id];

    always_comb begin
        free_idx  = '0;
        full      = 1'b1;
        any_valid = 1'b0;
        for (int i = NrOutstanding - 1; i >= 0; i--) begin
            if (!entries[i].valid) begin
                free_idx = IdWidth'(i);
                full     = 1'b0;
            end
            any_valid = any_valid | entries[i].valid;
        end
    end

endmodule

// File: rtl/cvxif_offload_ctrl.sv
// rtl/cvxif_offload_ctrl.sv - sequences custom instructions onto the CV-X-IF coprocessor port
module cvxif_offload_ctrl
    import cvxif_offload_ctrl_pkg::*;
#(
    parameter int XLEN          = CFG_XLEN,
    parameter int NrOutstanding = CFG_NR_OUTSTANDING,
    parameter int IdWidth       = $clog2(NrOutstanding)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [XLEN-1:0]     issue_rs1_i,
    input  logic [XLEN-1:0]     issue_rs2_i,
    input  logic [4:0]          issue_rd_i,
    output logic                accept_o,
    output logic                illegal_o,
    output logic                x_issue_valid_o,
    input  logic                x_issue_ready_i,
    output logic [31:0]         x_issue_instr_o,
    output logic [2*XLEN-1:0]   x_issue_rs_o,
    output logic [IdWidth-1:0]  x_issue_id_o,
    input  logic                x_issue_accept_i,
    input  logic                x_issue_writeback_i,
    output logic                x_commit_valid_o,
    output logic                x_commit_kill_o,
    output logic [IdWidth-1:0]  x_commit_id_o,
    input  logic                x_result_valid_i,
    output logic                x_result_ready_o,
    input  logic [IdWidth-1:0]  x_result_id_i,
    input  logic [XLEN-1:0]     x_result_data_i,
    input  logic [4:0]          x_result_rd_i,
    input  logic                x_result_we_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [XLEN-1:0]     wb_data_o,
    output logic [4:0]          wb_rd_o,
    output logic                busy_o,
    output logic                err_o
);

    state_e             state_q, state_d;
    logic               active_q;
    logic [31:0]        instr_q;
    logic [XLEN-1:0]    rs1_q, rs2_q;
    logic [4:0]         rd_q;
    logic [IdWidth-1:0] id_q;
    logic               flushed_q;

    logic               issue_fire;
    logic               alloc_en;
    entry_t             alloc_entry;
    entry_t             res_entry;
    logic [IdWidth-1:0] free_idx;
    logic               full, any_valid;
    logic               route, free_en;
    logic               unused_rd;

    assign issue_fire = issue_valid_i && issue_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (issue_fire) state_d = ST_REQ;
            ST_REQ:    if (x_issue_ready_i) state_d = x_issue_accept_i ? ST_COMMIT : ST_IDLE;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // active_q holds the core-side ready low for the first cycle after reset release.
    always_comb begin
        issue_ready_o    = 1'b0;
        x_issue_valid_o  = 1'b0;
        accept_o         = 1'b0;
        illegal_o        = 1'b0;
        x_commit_valid_o = 1'b0;
        x_commit_kill_o  = 1'b0;
        alloc_en         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                issue_ready_o = active_q && !full && !flush_i;
            end
            ST_REQ: begin
                x_issue_valid_o = 1'b1;
                if (x_issue_ready_i) begin
                    accept_o  = x_issue_accept_i;
                    illegal_o = !x_issue_accept_i;
                    alloc_en  = x_issue_accept_i;
                end
            end
            ST_COMMIT: begin
                x_commit_valid_o = 1'b1;
                x_commit_kill_o  = flushed_q || flush_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q  <= 1'b0;
            instr_q   <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            id_q      <= '0;
            flushed_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
            if (issue_fire) begin
                instr_q   <= issue_instr_i;
                rs1_q     <= issue_rs1_i;
                rs2_q     <= issue_rs2_i;
                rd_q      <= issue_rd_i;
                id_q      <= free_idx;
                flushed_q <= 1'b0;
            end else if (state_q == ST_REQ && flush_i) begin
                flushed_q <= 1'b1;
            end
        end
    end

    assign x_issue_instr_o = instr_q;
    assign x_issue_rs_o    = {rs2_q, rs1_q};
    assign x_issue_id_o    = id_q;
    assign x_commit_id_o   = id_q;

    // A request flushed while waiting for the coprocessor is allocated already killed.
    always_comb begin
        alloc_entry        = '0;
        alloc_entry.valid  = 1'b1;
        alloc_entry.wb     = x_issue_writeback_i;
        alloc_entry.killed = flushed_q || flush_i;
        alloc_entry.rd     = rd_q;
    end

    cvxif_id_table #(
        .NrOutstanding(NrOutstanding),
        .IdWidth      (IdWidth)
    ) u_id_table (
        .clk         (clk_i),
        .rst         (rst_i),
        .alloc_en    (alloc_en),
        .alloc_id    (id_q),
        .alloc_entry (alloc_entry),
        .kill_all    (flush_i),
        .free_en     (free_en),
        .free_id     (x_result_id_i),
        .lookup_id   (x_result_id_i),
        .lookup_entry(res_entry),
        .free_idx    (free_idx),
        .full        (full),
        .any_valid   (any_valid)
    );

    assign route            = res_entry.valid && !res_entry.killed && res_entry.wb && x_result_we_i;
    assign x_result_ready_o = active_q && (route ? wb_ready_i : 1'b1);
    assign wb_valid_o       = active_q && route && x_result_valid_i;
    assign err_o            = active_q && x_result_valid_i && !res_entry.valid;
    assign free_en          = x_result_valid_i && x_result_ready_o && res_entry.valid;
    assign wb_data_o        = x_result_data_i;
    assign wb_rd_o          = x_result_rd_i;
    assign busy_o           = any_valid || (state_q != ST_IDLE);

    // The stored rd is kept for debug visibility; writeback takes rd from the result.
    assign unused_rd = ^res_entry.rd;

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// tb/tb_cvxif_offload_ctrl.sv - self-checking bench for cvxif_offload_ctrl
module tb_cvxif_offload_ctrl;
    import cvxif_offload_ctrl_pkg::*;

    localparam int XL = CFG_XLEN;
    localparam int NR = CFG_NR_OUTSTANDING;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush_i = 1'b0;
    logic              issue_valid_i = 1'b0;
    logic              issue_ready_o;
    logic [31:0]       issue_instr_i = '0;
    logic [XL-1:0]     issue_rs1_i = '0, issue_rs2_i = '0;
    logic [4:0]        issue_rd_i = '0;
    logic              accept_o, illegal_o;
    logic              x_issue_valid_o;
    logic              x_issue_ready_i = 1'b0;
    logic [31:0]       x_issue_instr_o;
    logic [2*XL-1:0]   x_issue_rs_o;
    id_t               x_issue_id_o;
    logic              x_issue_accept_i = 1'b0, x_issue_writeback_i = 1'b0;
    logic              x_commit_valid_o, x_commit_kill_o;
    id_t               x_commit_id_o;
    logic              x_result_valid_i = 1'b0;
    logic              x_result_ready_o;
    id_t               x_result_id_i = '0;
    logic [XL-1:0]     x_result_data_i = '0;
    logic [4:0]        x_result_rd_i = '0;
    logic              x_result_we_i = 1'b0;
    logic              wb_valid_o;
    logic              wb_ready_i = 1'b0;
    logic [XL-1:0]     wb_data_o;
    logic [4:0]        wb_rd_o;
    logic              busy_o, err_o;

    int checks = 0;
    int failures = 0;

    // Reference view of the in-flight table: what the core believes is outstanding.
    bit         m_valid  [NR];
    bit         m_wb     [NR];
    bit         m_killed [NR];

    cvxif_offload_ctrl dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_instr_i(issue_instr_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
        .issue_rd_i(issue_rd_i), .accept_o(accept_o), .illegal_o(illegal_o),
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
        .x_issue_instr_o(x_issue_instr_o), .x_issue_rs_o(x_issue_rs_o), .x_issue_id_o(x_issue_id_o),
        .x_issue_accept_i(x_issue_accept_i), .x_issue_writeback_i(x_issue_writeback_i),
        .x_commit_valid_o(x_commit_valid_o), .x_commit_kill_o(x_commit_kill_o),
        .x_commit_id_o(x_commit_id_o),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i),
        .x_result_rd_i(x_result_rd_i), .x_result_we_i(x_result_we_i),
        .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_data_o(wb_data_o),
        .wb_rd_o(wb_rd_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int m_free();
        for (int i = 0; i < NR; i++) if (!m_valid[i]) return i;
        return -1;
    endfunction

    function automatic bit m_any();
        for (int i = 0; i < NR; i++) if (m_valid[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_flush();
        for (int i = 0; i < NR; i++) if (m_valid[i]) m_killed[i] = 1'b1;
    endfunction

    task automatic do_offload(input logic [31:0] instr, input logic [XL-1:0] r1, input logic [XL-1:0] r2,
                              input logic [4:0] rd, input bit acc, input bit wb, input bit flush_req,
                              input bit flush_commit, input int delay, output id_t got_id);
        int exp_id;
        exp_id = m_free();
        got_id = id_t'(exp_id);
        issue_instr_i = instr; issue_rs1_i = r1; issue_rs2_i = r2; issue_rd_i = rd;
        issue_valid_i = 1'b1;
        #1;
        chk("issue_ready", 64'(issue_ready_o), 64'(exp_id >= 0));
        tick();
        issue_valid_i = 1'b0;
        issue_instr_i = $urandom; issue_rs1_i = $urandom; issue_rs2_i = $urandom;
        #1;
        chk("x_issue_valid", 64'(x_issue_valid_o), 64'd1);
        chk("x_issue_id", 64'(x_issue_id_o), 64'(exp_id));
        chk("x_issue_instr", 64'(x_issue_instr_o), 64'(instr));
        chk("x_issue_rs", x_issue_rs_o, {r2, r1});
        flush_i = flush_req;
        for (int c = 0; c < delay; c++) begin
            tick();
            if (flush_req) m_flush();
            #1;
            chk("x_issue_valid_hold", 64'(x_issue_valid_o), 64'd1);
            chk("x_issue_instr_hold", 64'(x_issue_instr_o), 64'(instr));
        end
        x_issue_ready_i = 1'b1; x_issue_accept_i = acc; x_issue_writeback_i = wb;
        #1;
        chk("accept", 64'(accept_o), 64'(acc));
        chk("illegal", 64'(illegal_o), 64'(!acc));
        tick();
        if (flush_req) m_flush();
        if (acc) begin
            m_valid[exp_id] = 1'b1; m_wb[exp_id] = wb; m_killed[exp_id] = flush_req;
        end
        x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;
        flush_i = flush_commit;
        #1;
        chk("commit_valid", 64'(x_commit_valid_o), 64'(acc));
        chk("commit_kill", 64'(x_commit_kill_o), 64'(acc && (flush_req || flush_commit)));
        chk("commit_id", 64'(x_commit_id_o), 64'(exp_id));
        chk("x_issue_valid_drop", 64'(x_issue_valid_o), 64'd0);
        tick();
        if (flush_commit) m_flush();
        flush_i = 1'b0;
        #1;
        chk("busy_after", 64'(busy_o), 64'(m_any()));
    endtask

    task automatic send_result(input id_t id, input logic [XL-1:0] data, input logic [4:0] rd,
                               input bit we, input int stall);
        bit hit, route;
        hit   = m_valid[id];
        route = hit && !m_killed[id] && m_wb[id] && we;
        x_result_valid_i = 1'b1; x_result_id_i = id; x_result_data_i = data;
        x_result_rd_i = rd; x_result_we_i = we; wb_ready_i = 1'b0;
        if (route) begin
            for (int c = 0; c < stall; c++) begin
                #1;
                chk("res_ready_stall", 64'(x_result_ready_o), 64'd0);
                chk("wb_valid_stall", 64'(wb_valid_o), 64'd1);
                tick();
            end
        end
        wb_ready_i = 1'b1;
        #1;
        chk("res_ready", 64'(x_result_ready_o), 64'd1);
        chk("wb_valid", 64'(wb_valid_o), 64'(route));
        chk("err", 64'(err_o), 64'(!hit));
        chk("wb_data", 64'(wb_data_o), 64'(data));
        chk("wb_rd", 64'(wb_rd_o), 64'(rd));
        tick();
        if (hit) begin
            m_valid[id] = 1'b0; m_killed[id] = 1'b0; m_wb[id] = 1'b0;
        end
        x_result_valid_i = 1'b0; x_result_we_i = 1'b0; wb_ready_i = 1'b0;
        x_result_data_i = '0; x_result_rd_i = '0; x_result_id_i = '0;
        #1;
        chk("err_clear", 64'(err_o), 64'd0);
    endtask

    initial begin
        id_t got;
        id_t rid;
        int  nf;

        // Reset values, then ready one cycle after release
        #12;
        chk("rst_ctrl", {13'd0, issue_ready_o, accept_o, illegal_o, x_issue_valid_o, x_commit_valid_o,
                         x_commit_kill_o, x_result_ready_o, wb_valid_o, busy_o, err_o,
                         x_issue_id_o, x_commit_id_o, wb_rd_o, wb_data_o}, 64'd0);
        chk("rst_instr", 64'(x_issue_instr_o), 64'd0);
        chk("rst_rs", x_issue_rs_o, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_release", 64'(issue_ready_o), 64'd0);
        tick();
        chk("ready_next_cycle", 64'(issue_ready_o), 64'd1);

        // Accept with writeback
        do_offload(32'h0000_000B, 32'd5, 32'd7, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 0, got);
        send_result(got, 32'd12, 5'd3, 1'b1, 0);

        // Reject
        do_offload(32'h0000_002B, 32'd1, 32'd2, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1, got);

        // Fill the table, then free ID 2 and reuse it
        for (int i = 0; i < NR; i++)
            do_offload($urandom, $urandom, $urandom, 5'($urandom_range(31)), 1'b1, 1'b1, 1'b0, 1'b0, 0, got);
        chk("full_ready", 64'(issue_ready_o), 64'(m_free() >= 0));
        chk("full_busy", 64'(busy_o), 64'd1);
        send_result(id_t'(2), 32'hCAFE_0002, 5'd9, 1'b1, 0);
        chk("ready_after_free", 64'(issue_ready_o), 64'd1);
        do_offload($urandom, $urandom, $urandom, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0, 0, got);
        for (int i = 0; i < NR; i++) send_result(id_t'(i), $urandom, 5'($urandom_range(31)), 1'b1, 0);

        // Flush during REQ and during COMMIT
        do_offload(32'h0000_005B, 32'd3, 32'd4, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 2, got);
        send_result(got, 32'h1234, 5'd6, 1'b1, 0);
        do_offload(32'h0000_007B, 32'd8, 32'd9, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 0, got);
        send_result(got, 32'h5678, 5'd7, 1'b1, 0);

        // Writeback stall
        do_offload(32'h0000_000B, 32'd11, 32'd12, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 0, got);
        send_result(got, 32'hBEEF, 5'd8, 1'b1, 3);

        // Bad ID
        send_result(id_t'(1), 32'hDEAD, 5'd1, 1'b1, 0);

        // Randomized mix against the model
        for (int it = 0; it < 60; it++) begin
            nf = m_free();
            if (nf >= 0 && ($urandom_range(1) == 0)) begin
                do_offload($urandom, $urandom, $urandom, 5'($urandom_range(31)),
                           ($urandom_range(3) != 0), 1'($urandom_range(1)),
                           ($urandom_range(7) == 0), ($urandom_range(7) == 0),
                           $urandom_range(2), got);
            end else begin
                rid = id_t'($urandom_range(NR - 1));
                send_result(rid, $urandom, 5'($urandom_range(31)), 1'($urandom_range(1)),
                            $urandom_range(2));
            end
        end
        for (int i = 0; i < NR; i++)
            if (m_valid[i]) send_result(id_t'(i), $urandom, 5'($urandom_range(31)), 1'b1, 1);
        chk("drained_busy", 64'(busy_o), 64'd0);

        // Reset asserted while in COMMIT
        issue_instr_i = 32'h0000_000B; issue_valid_i = 1'b1;
        tick();
        issue_valid_i = 1'b0;
        x_issue_ready_i = 1'b1; x_issue_accept_i = 1'b1; x_issue_writeback_i = 1'b1;
        tick();
        x_issue_ready_i = 1'b0; x_issue_accept_i = 1'b0; x_issue_writeback_i = 1'b0;
        #1;
        chk("pre_rst_commit", 64'(x_commit_valid_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("rst_commit_ctrl", {13'd0, issue_ready_o, accept_o, illegal_o, x_issue_valid_o, x_commit_valid_o,
                                x_commit_kill_o, x_result_ready_o, wb_valid_o, busy_o, err_o,
                                x_issue_id_o, x_commit_id_o, wb_rd_o, wb_data_o}, 64'd0);
        chk("rst_commit_instr", 64'(x_issue_instr_o), 64'd0);
        chk("rst_commit_rs", x_issue_rs_o, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cvxif_offload_ctrl.md
# cvxif_offload_ctrl

Sequences custom instructions from the issue stage onto the CV-X-IF coprocessor port. Enabled when the core configuration has the X-interface on and XLEN is 32. Three jobs: runs the issue/accept handshake, sends one commit or kill per offload, and keeps a table of up to NrOutstanding in-flight IDs. It routes coprocessor results to the integer writeback port, or drops them when the instruction was killed or has no writeback.

## Interface
- XLEN, 32: operand/result width (taken from the core configuration package).
- NrOutstanding, 4: maximum in-flight offload IDs.
- IdWidth, $clog2(NrOutstanding): transaction ID width.
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  pipeline flush; kills the pending offload and all outstanding ones.
- issue_valid_i / issue_ready_o  in/out  1  core-side offload handshake.
- issue_instr_i  in  32  instruction word.
- issue_rs1_i, issue_rs2_i  in  XLEN  operands.
- issue_rd_i  in  5  destination register.
- accept_o / illegal_o  out  1  one-cycle outcome pulse per offload.
- x_issue_valid_o / x_issue_ready_i  out/in  1  coprocessor issue handshake.
- x_issue_instr_o  out  32;  x_issue_rs_o  out  2*XLEN ({rs2,rs1});  x_issue_id_o  out  IdWidth.
- x_issue_accept_i, x_issue_writeback_i  in  1  coprocessor decision, valid with x_issue_ready_i.
- x_commit_valid_o, x_commit_kill_o  out  1;  x_commit_id_o  out  IdWidth.
- x_result_valid_i / x_result_ready_o  in/out  1;  x_result_id_i  in  IdWidth;  x_result_data_i  in  XLEN;  x_result_rd_i  in  5;  x_result_we_i  in  1.
- wb_valid_o / wb_ready_i  out/in  1;  wb_data_o  out  XLEN;  wb_rd_o  out  5.
- busy_o  out  1  any entry valid or state != IDLE.
- err_o  out  1  one-cycle pulse when a result arrives for an invalid ID.

## Operation
- FSM states are IDLE, REQ and COMMIT.
  - IDLE: issue_ready_o = free ID exists && !flush_i. On a transfer, the block latches instr, operands, rd and the lowest free ID, then moves to REQ.
  - REQ: x_issue_valid_o=1 and the payload is held stable until x_issue_ready_i.
    - On ready with accept=1: set entry[id] {valid=1, wb=x_issue_writeback_i, killed=0, rd}, pulse accept_o, go to COMMIT.
    - On ready with accept=0: pulse illegal_o, allocate no entry, go to IDLE.
  - COMMIT: x_commit_valid_o=1 for exactly one cycle with x_commit_id_o=id, then go to IDLE.
- Flush:
  - A flush during REQ does not drop valid; the request stays up until ready.
  - If the flushed request is then accepted, COMMIT drives kill=1 and the entry is marked killed.
  - A flush during COMMIT forces kill=1 that same cycle.
  - A flush in any state sets killed=1 on every valid entry.
- Results:
  - Valid ID, not killed, wb=1 and x_result_we_i=1: wb_valid_o=x_result_valid_i, and x_result_ready_o=wb_ready_i.
  - Any other valid ID: x_result_ready_o=1, the result is dropped and wb_valid_o=0.
  - The entry is cleared on the result handshake.
  - Invalid ID: ready=1, dropped, err_o pulses.
- wb_rd_o = x_result_rd_i, wb_data_o = x_result_data_i.

## Timing
- Reset values: state IDLE, table cleared, all outputs 0 (issue_ready_o rises the cycle after reset release).
- Core transfer to x_issue_valid_o: 1 cycle.
- x_issue_ready_i handshake to x_commit_valid_o: 1 cycle.
- Result to writeback: combinational, 0 cycles.
- An ID freed by a result in cycle N can be allocated in cycle N+1. Allocation uses the free mask registered at the start of the cycle.
- Full (all entries valid): issue_ready_o=0 until a result handshake completes.
- Reset asserted mid-operation: immediate return to reset values. Outstanding coprocessor transactions are abandoned.

## Structure
- The shared CV-X-IF package holds the FSM state enum, the entry struct {valid, wb, killed, rd[4:0]} and the ID type.
- One sub-module, cvxif_id_table, holds the entry array with allocate, kill-all and free ports, plus lowest-free-index encoder and full flag.

## Test plan
- Accept with writeback:
  - Stimulus: instr 0x0000_000B, rs1=5, rs2=7, then result data 12 on ID 0 with we=1.
  - Required: x_issue_valid_o the next cycle; commit ID0 kill=0; wb_valid_o with data 12 and rd matching.
- Reject:
  - Stimulus: x_issue_accept_i=0.
  - Required: illegal_o pulses once; no commit; busy_o=0 the next cycle.
- Fill:
  - Stimulus: 4 accepted offloads with no results.
  - Required: IDs 0,1,2,3 allocated; issue_ready_o=0.
  - Follow-up: a result on ID 2 makes issue_ready_o=1 the next cycle and the next allocation gets ID 2.
- Flush during REQ:
  - Stimulus: flush_i held in REQ until ready, with accept=1.
  - Required: x_issue_valid_o stays high until ready; commit has kill=1.
  - Follow-up: the later result on that ID gets ready=1 and wb_valid_o=0.
- Writeback stall:
  - Stimulus: wb_ready_i=0 for 3 cycles during a valid result.
  - Required: x_result_ready_o=0 for those cycles; transfer completes when wb_ready_i=1.
- Bad ID and reset:
  - Stimulus: a result on an unallocated ID.
  - Required: err_o pulses and the result is dropped.
  - Stimulus: rst_i asserted while in COMMIT.
  - Required: all outputs 0 immediately.
